// File: rtl/clock_group_pkg.sv
// Shared clock-group definitions: sequencer state encoding and default build constants.
package clock_group_pkg;

    localparam int unsigned DEF_NUM_MEMBERS = 6;
    localparam int unsigned DEF_HOLD_CYCLES = 16;
    localparam int unsigned DEF_GAP_CYCLES  = 4;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        ST_ASSERT  = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_GAP     = 3'd3,
        ST_IDLE    = 3'd4
    } seq_state_e;

    // Largest of three values, used to size the shared hold/gap counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/reset_req_sync.sv
// Multi-flop synchronizer for asynchronous, level-sensitive reset request lines.
module reset_req_sync #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= i_async;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_sync = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/clock_group_reset_sequencer.sv
// Drives per-member resets of a clock group: assert all, hold, then release members
// one at a time in ascending order with a gap between releases.
module clock_group_reset_sequencer
    import clock_group_pkg::*;
#(
    parameter int unsigned NUM_MEMBERS = DEF_NUM_MEMBERS,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_MEMBERS-1:0] req_reset,
    input  logic                   trig_valid,
    output logic                   trig_ready,
    output logic [NUM_MEMBERS-1:0] member_reset,
    output logic                   seq_busy,
    output logic                   seq_done
);

    localparam int unsigned CNT_W = $clog2(max3(HOLD_CYCLES, GAP_CYCLES, 2));
    localparam int unsigned IDX_W = (NUM_MEMBERS > 1) ? $clog2(NUM_MEMBERS) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_MEMBERS - 1);

    seq_state_e             r_state;
    seq_state_e             w_state_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_idx_next;
    logic [NUM_MEMBERS-1:0] r_member_reset;
    logic [NUM_MEMBERS-1:0] w_member_reset_next;
    logic                   r_trig_ready;
    logic                   r_seq_busy;
    logic                   r_seq_done;
    logic                   w_done_next;
    logic [NUM_MEMBERS-1:0] w_sync;
    logic                   w_sreq;

    reset_req_sync #(
        .WIDTH       (NUM_MEMBERS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .i_async (req_reset),
        .o_sync  (w_sync)
    );

    assign w_sreq = |w_sync;

    // State, counters and all outputs are registered from the next-state decode.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_ASSERT;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_member_reset <= '1;
            r_trig_ready   <= 1'b0;
            r_seq_busy     <= 1'b1;
            r_seq_done     <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_idx          <= w_idx_next;
            r_member_reset <= w_member_reset_next;
            r_trig_ready   <= (w_state_next == ST_IDLE);
            r_seq_busy     <= (w_state_next != ST_IDLE);
            r_seq_done     <= w_done_next;
        end
    end

    always_comb begin
        w_state_next        = r_state;
        w_cnt_next          = r_cnt;
        w_idx_next          = r_idx;
        w_member_reset_next = r_member_reset;
        w_done_next         = 1'b0;

        case (r_state)
            ST_ASSERT: begin
                w_state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state_next = ST_RELEASE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (r_idx == IDX_LAST) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end else begin
                    w_idx_next   = r_idx + IDX_W'(1);
                    w_cnt_next   = '0;
                    w_state_next = (GAP_CYCLES == 0) ? ST_RELEASE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_next = ST_RELEASE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (trig_valid && r_trig_ready) begin
                    w_state_next = ST_ASSERT;
                end
            end
            default: begin
                w_state_next = ST_ASSERT;
            end
        endcase

        // A synchronized request overrides everything and restarts the sequence.
        if (w_sreq) begin
            w_state_next = ST_ASSERT;
            w_done_next  = 1'b0;
        end

        if (w_state_next == ST_ASSERT) begin
            w_cnt_next          = '0;
            w_idx_next          = '0;
            w_member_reset_next = '1;
        end else if (w_state_next == ST_RELEASE) begin
            w_member_reset_next[w_idx_next] = 1'b0;
        end
    end

    assign trig_ready   = r_trig_ready;
    assign member_reset = r_member_reset;
    assign seq_busy     = r_seq_busy;
    assign seq_done     = r_seq_done;

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// Self-checking bench: two sequencer builds (GAP=4 and GAP=0) against a timeline model.
module tb_clock_group_reset_sequencer;

    localparam int N = 6;
    localparam int H = 16;
    localparam int S = 2;

    logic         clock = 1'b0;
    logic         reset_n = 1'b1;
    logic [N-1:0] req_reset = '0;
    logic         trig_valid = 1'b0;

    logic [N-1:0] mr_o   [2];
    logic         rdy_o  [2];
    logic         busy_o [2];
    logic         done_o [2];

    int errors = 0;
    int checks = 0;
    logic check_en = 1'b0;

    always #5 clock = ~clock;

    clock_group_reset_sequencer #(.NUM_MEMBERS(N), .HOLD_CYCLES(H), .GAP_CYCLES(4),
                                  .SYNC_STAGES(S)) u_dut_a (
        .clock(clock), .reset_n(reset_n), .req_reset(req_reset), .trig_valid(trig_valid),
        .trig_ready(rdy_o[0]), .member_reset(mr_o[0]), .seq_busy(busy_o[0]),
        .seq_done(done_o[0]));

    clock_group_reset_sequencer #(.NUM_MEMBERS(N), .HOLD_CYCLES(H), .GAP_CYCLES(0),
                                  .SYNC_STAGES(S)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .req_reset(req_reset), .trig_valid(trig_valid),
        .trig_ready(rdy_o[1]), .member_reset(mr_o[1]), .seq_busy(busy_o[1]),
        .seq_done(done_o[1]));

    // Model: t = cycles since the current sequence started (0 = all asserted).
    int           t_m [2] = '{0, 0};
    logic [N-1:0] sync_m [S];

    function automatic int gap_of(input int i);
        return (i == 0) ? 4 : 0;
    endfunction

    function automatic int t_idle(input int g);
        return 1 + H + (N - 1) * (g + 1) + 1;
    endfunction

    function automatic logic [N-1:0] exp_mr(input int t, input int g);
        logic [N-1:0] m;
        m = '1;
        for (int j = 0; j < N; j++) begin
            if (t >= 1 + H + j * (g + 1)) m[j] = 1'b0;
        end
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) t_m[i] <= 0;
            for (int k = 0; k < S; k++) sync_m[k] <= '0;
        end else begin
            for (int k = 1; k < S; k++) sync_m[k] <= sync_m[k-1];
            sync_m[0] <= req_reset;
            for (int i = 0; i < 2; i++) begin
                if (|sync_m[S-1]) t_m[i] <= 0;
                else if (t_m[i] >= t_idle(gap_of(i)) && trig_valid) t_m[i] <= 0;
                else if (t_m[i] <= t_idle(gap_of(i))) t_m[i] <= t_m[i] + 1;
            end
        end
    end

    always @(negedge clock) begin
        if (check_en) begin
            for (int i = 0; i < 2; i++) begin
                chk(i == 0 ? "model_mr_a" : "model_mr_b", 32'(mr_o[i]),
                    32'(exp_mr(t_m[i], gap_of(i))));
                chk(i == 0 ? "model_ready_a" : "model_ready_b", 32'(rdy_o[i]),
                    32'(t_m[i] >= t_idle(gap_of(i))));
                chk(i == 0 ? "model_busy_a" : "model_busy_b", 32'(busy_o[i]),
                    32'(t_m[i] < t_idle(gap_of(i))));
                chk(i == 0 ? "model_done_a" : "model_done_b", 32'(done_o[i]),
                    32'(t_m[i] == t_idle(gap_of(i))));
            end
        end
    end

    task automatic trigger();
        trig_valid = 1'b1;
        @(negedge clock);
        trig_valid = 1'b0;
    endtask

    int n_done [2];
    int n_rise [2];
    logic prev_busy [2];

    initial begin
        #1 reset_n = 1'b0;
        #1 check_en = 1'b1;
        chk("rst_mr_a", 32'(mr_o[0]), 32'h3F);
        chk("rst_ready_a", 32'(rdy_o[0]), 32'h0);
        chk("rst_done_a", 32'(done_o[0]), 32'h0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // Power-on timeline, both builds.
        for (int c = 1; c <= 45; c++) begin
            @(negedge clock);
            case (c)
                16: chk("pwr_mr_a_c16", 32'(mr_o[0]), 32'h3F);
                17: begin
                    chk("pwr_mr_a_c17", 32'(mr_o[0]), 32'h3E);
                    chk("pwr_mr_b_c17", 32'(mr_o[1]), 32'h3E);
                end
                18: chk("pwr_mr_b_c18", 32'(mr_o[1]), 32'h3C);
                22: begin
                    chk("pwr_mr_a_c22", 32'(mr_o[0]), 32'h3C);
                    chk("pwr_mr_b_c22", 32'(mr_o[1]), 32'h00);
                end
                23: chk("pwr_done_b_c23", 32'(done_o[1]), 32'h1);
                41: chk("pwr_mr_a_c41", 32'(mr_o[0]), 32'h20);
                42: begin
                    chk("pwr_mr_a_c42", 32'(mr_o[0]), 32'h00);
                    chk("pwr_done_a_c42", 32'(done_o[0]), 32'h0);
                end
                43: begin
                    chk("pwr_done_a_c43", 32'(done_o[0]), 32'h1);
                    chk("pwr_ready_a_c43", 32'(rdy_o[0]), 32'h1);
                end
                44: chk("pwr_done_a_c44", 32'(done_o[0]), 32'h0);
                default: ;
            endcase
        end

        // Software trigger: same timeline relative to the handshake.
        trigger();
        chk("trig_ready_a_d1", 32'(rdy_o[0]), 32'h0);
        chk("trig_mr_a_d1", 32'(mr_o[0]), 32'h3F);
        for (int d = 2; d <= 46; d++) begin
            @(negedge clock);
            if (d == 18) chk("trig_mr_a_d18", 32'(mr_o[0]), 32'h3E);
            if (d == 44) chk("trig_done_a_d44", 32'(done_o[0]), 32'h1);
        end

        // Request arriving mid-GAP at idx 2, held for a while, then released.
        trigger();
        for (int d = 2; d <= 24; d++) @(negedge clock);
        req_reset = 6'b001000;
        repeat (3) @(negedge clock);
        chk("req_mr_a_3cyc", 32'(mr_o[0]), 32'h3F);
        repeat (8) @(negedge clock);
        chk("req_held_mr_a", 32'(mr_o[0]), 32'h3F);
        chk("req_held_busy_a", 32'(busy_o[0]), 32'h1);
        req_reset = '0;
        repeat (60) @(negedge clock);
        chk("req_restart_idle_a", 32'(rdy_o[0]), 32'h1);

        // Reset abort during RELEASE of idx 4.
        trigger();
        for (int d = 2; d <= 38; d++) @(negedge clock);
        chk("abort_pre_mr_a", 32'(mr_o[0]), 32'h20);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_mr_a", 32'(mr_o[0]), 32'h3F);
        chk("abort_done_a", 32'(done_o[0]), 32'h0);
        chk("abort_mr_b", 32'(mr_o[1]), 32'h3F);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (50) @(negedge clock);

        // Randomized requests and triggers against the model.
        for (int r = 0; r < 1500; r++) begin
            @(negedge clock);
            trig_valid = ($urandom_range(0, 3) == 0);
            if (req_reset != '0) begin
                if ($urandom_range(0, 3) == 0) req_reset = '0;
            end else if ($urandom_range(0, 63) == 0) begin
                req_reset = N'(1 << $urandom_range(0, N - 1));
            end
        end
        @(negedge clock);
        trig_valid = 1'b0;
        req_reset = '0;
        repeat (60) @(negedge clock);

        // Collision: synchronized request and trigger in the same IDLE cycle.
        req_reset = 6'b000001;
        @(negedge clock);
        req_reset = '0;
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            n_done[i] = 0;
            n_rise[i] = 0;
            prev_busy[i] = busy_o[i];
        end
        trig_valid = 1'b1;
        for (int d = 1; d <= 60; d++) begin
            @(negedge clock);
            trig_valid = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (done_o[i]) n_done[i]++;
                if (busy_o[i] && !prev_busy[i]) n_rise[i]++;
                prev_busy[i] = busy_o[i];
            end
        end
        chk("coll_done_cnt_a", 32'(n_done[0]), 32'd1);
        chk("coll_done_cnt_b", 32'(n_done[1]), 32'd1);
        chk("coll_assert_cnt_a", 32'(n_rise[0]), 32'd1);
        chk("coll_assert_cnt_b", 32'(n_rise[1]), 32'd1);

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
